// File: rtl/sample_bridge_pkg.sv
// Shared types for sample_bridge: FSM state encoding, overrun counter width
// and its saturating increment.
package sample_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    EMIT      = 2'd3
  } state_e;

  localparam int OVR_W = 8;

  typedef logic [OVR_W-1:0] ovr_cnt_t;

  function automatic ovr_cnt_t ovr_sat_inc(input ovr_cnt_t cnt);
    if (cnt == {OVR_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + ovr_cnt_t'(1);
    end
  endfunction

endpackage

// File: rtl/sample_bridge_toggle_sync.sv
// toggle_sync: two-flop synchroniser for the asynchronous rx_toggle flag plus
// one history flop; event_o pulses one cycle per input transition.
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic toggle_i,
  output logic event_o
);

  // [0],[1] synchronise, [2] holds the previous synchronised level
  logic [2:0] sync_q;

  // Synchroniser and history shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], toggle_i};
    end
  end

  assign event_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/sample_bridge.sv
// sample_bridge: hands I2S receive samples to a processing engine and returns
// its results to the I2S transmitter. Optional macro SAMPLE_BRIDGE_ROUND_EN
// selects round-half-up with saturation instead of truncation on the way in.
module sample_bridge
  import sample_bridge_pkg::*;
#(
  parameter int IN_WIDTH       = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   rx_sample,
  input  logic                  rx_toggle,
  output logic [DATA_WIDTH-1:0] eng_in_sample,
  output logic                  eng_sample_ready,
  input  logic                  eng_ready,
  input  logic [DATA_WIDTH-1:0] eng_out_sample,
  output logic [IN_WIDTH-1:0]   tx_sample,
  output logic                  tx_valid,
  output logic [OVR_W-1:0]      overrun_count,
  output logic                  timeout
);

  localparam int SHIFT = IN_WIDTH - DATA_WIDTH;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  rx_event_s;
  logic [DATA_WIDTH-1:0] conv_s;
  logic                  unused_rx_s;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] eng_in_q, eng_in_d;
  logic                  eng_rdy_q, eng_rdy_d;
  logic [IN_WIDTH-1:0]   tx_q, tx_d;
  logic                  tx_vld_q, tx_vld_d;
  ovr_cnt_t              ovr_q, ovr_d;
  logic                  tmo_flag_q, tmo_flag_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

  toggle_sync u_toggle_sync (
    .clk      (clk),
    .reset    (reset),
    .toggle_i (rx_toggle),
    .event_o  (rx_event_s)
  );

  // Only the low bits below the engine word feed rounding, if at all
  assign unused_rx_s = ^rx_sample[SHIFT-1:0];

`ifdef SAMPLE_BRIDGE_ROUND_EN
  logic [DATA_WIDTH:0] rnd_s;

  // One extra bit catches the single positive overflow case (max + 1)
  assign rnd_s = {rx_sample[IN_WIDTH-1], rx_sample[IN_WIDTH-1:SHIFT]}
               + {{DATA_WIDTH{1'b0}}, rx_sample[SHIFT-1]};

  // Saturate rounded value back into the signed engine range
  always_comb begin
    if (rnd_s[DATA_WIDTH] != rnd_s[DATA_WIDTH-1]) begin
      if (rnd_s[DATA_WIDTH]) begin
        conv_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        conv_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      conv_s = rnd_s[DATA_WIDTH-1:0];
    end
  end
`else
  assign conv_s = rx_sample[IN_WIDTH-1:SHIFT];
`endif

  // Next-state and output logic of the bridge FSM
  always_comb begin
    state_d    = state_q;
    eng_in_d   = eng_in_q;
    eng_rdy_d  = 1'b0;
    tx_d       = tx_q;
    tx_vld_d   = 1'b0;
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;

    if (rx_event_s && (state_q != IDLE)) begin
      ovr_d = ovr_sat_inc(ovr_q);
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_event_s) begin
          eng_in_d  = conv_s;
          eng_rdy_d = 1'b1;
          tmo_cnt_d = {TW{1'b0}};
          state_d   = WAIT_BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tmo_cnt_q == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          state_d    = IDLE;
        end else if (!eng_ready) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          state_d   = WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (tmo_cnt_q == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          state_d    = IDLE;
        end else if (eng_ready) begin
          // Sign extension bits are shifted out, so a plain concat suffices
          tx_d     = {eng_out_sample, {SHIFT{1'b0}}};
          tx_vld_d = 1'b1;
          state_d  = EMIT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      eng_in_q   <= {DATA_WIDTH{1'b0}};
      eng_rdy_q  <= 1'b0;
      tx_q       <= {IN_WIDTH{1'b0}};
      tx_vld_q   <= 1'b0;
      ovr_q      <= {OVR_W{1'b0}};
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= {TW{1'b0}};
    end else begin
      state_q    <= state_d;
      eng_in_q   <= eng_in_d;
      eng_rdy_q  <= eng_rdy_d;
      tx_q       <= tx_d;
      tx_vld_q   <= tx_vld_d;
      ovr_q      <= ovr_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign eng_in_sample    = eng_in_q;
  assign eng_sample_ready = eng_rdy_q;
  assign tx_sample        = tx_q;
  assign tx_valid         = tx_vld_q;
  assign overrun_count    = ovr_q;
  assign timeout          = tmo_flag_q;

endmodule

// File: tb/tb_sample_bridge.sv
// Directed self-checking bench for sample_bridge with a simple engine model.
module tb_sample_bridge;

  logic        clk;
  logic        reset;
  logic [23:0] rx_sample;
  logic        rx_toggle;
  logic [15:0] eng_in_sample;
  logic        eng_sample_ready;
  logic        eng_ready;
  logic [15:0] eng_out_sample;
  logic [23:0] tx_sample;
  logic        tx_valid;
  logic [7:0]  overrun_count;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int esr_cnt = 0;
  int txv_cnt = 0;
  int cyc = 0;
  logic        eng_auto = 1'b1;
  logic [15:0] eng_result = 16'h0000;

  sample_bridge dut (
    .clk              (clk),
    .reset            (reset),
    .rx_sample        (rx_sample),
    .rx_toggle        (rx_toggle),
    .eng_in_sample    (eng_in_sample),
    .eng_sample_ready (eng_sample_ready),
    .eng_ready        (eng_ready),
    .eng_out_sample   (eng_out_sample),
    .tx_sample        (tx_sample),
    .tx_valid         (tx_valid),
    .overrun_count    (overrun_count),
    .timeout          (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_sample_ready === 1'b1) esr_cnt <= esr_cnt + 1;
    if (tx_valid === 1'b1) txv_cnt <= txv_cnt + 1;
  end

  // Engine: drops ready 2 cycles after a submit, raises it 10 cycles later
  initial begin
    eng_ready = 1'b1;
    eng_out_sample = 16'h0000;
    forever begin
      @(negedge clk);
      if (eng_auto && eng_sample_ready === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 eng_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 eng_out_sample = eng_result;
        eng_ready = 1'b1;
      end
    end
  end

  task automatic do_toggle(input logic [23:0] s);
    @(posedge clk);
    #1;
    rx_sample = s;
    rx_toggle = ~rx_toggle;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx_sample = 24'h000000;
    rx_toggle = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({eng_in_sample, tx_sample, overrun_count} !== 48'h0 ||
        {eng_sample_ready, tx_valid, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got eng_in=%h tx=%h ovr=%0d esr=%b txv=%b tmo=%b, want all zero",
               eng_in_sample, tx_sample, overrun_count, eng_sample_ready, tx_valid, timeout);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    wait_cycles(5);
    checks++;
    if (esr_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_event: got %0d submits, want 0", esr_cnt);
    end
  endtask

  task automatic run_sample(input string name, input logic [23:0] s, input logic [15:0] res,
                            input logic [15:0] exp_in, input logic [23:0] exp_tx);
    int e0, t0;
    e0 = esr_cnt;
    t0 = txv_cnt;
    eng_result = res;
    do_toggle(s);
    wait_cycles(40);
    checks++;
    if (eng_in_sample !== exp_in) begin
      errors++;
      $display("FAIL %s eng_in: got %h, want %h", name, eng_in_sample, exp_in);
    end
    checks++;
    if (tx_sample !== exp_tx) begin
      errors++;
      $display("FAIL %s tx_sample: got %h, want %h", name, tx_sample, exp_tx);
    end
    checks++;
    if ((esr_cnt - e0) !== 1 || (txv_cnt - t0) !== 1) begin
      errors++;
      $display("FAIL %s strobes: got submits=%0d tx_valids=%0d, want 1 and 1",
               name, esr_cnt - e0, txv_cnt - t0);
    end
  endtask

  task automatic test_basic;
`ifdef SAMPLE_BRIDGE_ROUND_EN
    run_sample("basic", 24'h123480, 16'h0042, 16'h1235, 24'h004200);
`else
    run_sample("basic", 24'h123480, 16'h0042, 16'h1234, 24'h004200);
`endif
    checks++;
    if (overrun_count !== 8'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got ovr=%0d tmo=%b, want 0 0", overrun_count, timeout);
    end
  endtask

  task automatic test_saturation;
    run_sample("sat_pos", 24'h7FFF80, 16'hFFFE, 16'h7FFF, 24'hFFFE00);
    run_sample("sat_neg", 24'h800000, 16'h8001, 16'h8000, 24'h800100);
  endtask

  task automatic test_overrun;
    int e0, t0;
    e0 = esr_cnt;
    t0 = txv_cnt;
    eng_result = 16'h1111;
    do_toggle(24'h010000);
    repeat (4) @(posedge clk);
    do_toggle(24'h020000);
    wait_cycles(40);
    checks++;
    if (overrun_count !== 8'd1) begin
      errors++;
      $display("FAIL overrun_one: got %0d, want 1", overrun_count);
    end
    checks++;
    if ((esr_cnt - e0) !== 1 || (txv_cnt - t0) !== 1) begin
      errors++;
      $display("FAIL overrun_strobes: got submits=%0d tx_valids=%0d, want 1 and 1",
               esr_cnt - e0, txv_cnt - t0);
    end
    checks++;
    if (eng_in_sample !== 16'h0100 || tx_sample !== 24'h111100) begin
      errors++;
      $display("FAIL overrun_data: got eng_in=%h tx=%h, want 0100 111100", eng_in_sample, tx_sample);
    end
  endtask

  task automatic test_timeout_saturate;
    int c0, t0, guard;
    t0 = txv_cnt;
    eng_auto = 1'b0;
    do_toggle(24'h030000);
    guard = 0;
    c0 = -1;
    while (c0 < 0 && guard < 20) begin
      @(negedge clk);
      if (eng_sample_ready === 1'b1) c0 = cyc;
      guard++;
    end
    checks++;
    if (c0 < 0) begin
      errors++;
      $display("FAIL timeout_submit: no eng_sample_ready within 20 cycles, want 1");
      c0 = cyc;
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 rx_toggle = ~rx_toggle;
    end
    wait_cycles(6);
    checks++;
    if (overrun_count !== 8'd255) begin
      errors++;
      $display("FAIL overrun_sat: got %0d, want 255", overrun_count);
    end
    while (cyc < c0 + 4095) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b one cycle before limit, want 0", timeout);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set: got %b at limit, want 1", timeout);
    end
    checks++;
    if ((txv_cnt - t0) !== 0 || tx_sample !== 24'h111100) begin
      errors++;
      $display("FAIL timeout_no_tx: got tx_valids=%0d tx=%h, want 0 111100", txv_cnt - t0, tx_sample);
    end
    eng_auto = 1'b1;
    wait_cycles(5);
`ifdef SAMPLE_BRIDGE_ROUND_EN
    run_sample("after_timeout", 24'hFFFF80, 16'h8000, 16'h0000, 24'h800000);
`else
    run_sample("after_timeout", 24'hFFFF80, 16'h8000, 16'hFFFF, 24'h800000);
`endif
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, want 1", timeout);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    t0 = txv_cnt;
    eng_result = 16'h5555;
    do_toggle(24'h040000);
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    rx_toggle = 1'b0;
    @(negedge clk);
    checks++;
    if ({eng_in_sample, tx_sample, overrun_count} !== 48'h0 ||
        {eng_sample_ready, tx_valid, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got eng_in=%h tx=%h ovr=%0d esr=%b txv=%b tmo=%b, want all zero",
               eng_in_sample, tx_sample, overrun_count, eng_sample_ready, tx_valid, timeout);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_cycles(25);
    checks++;
    if ((txv_cnt - t0) !== 0 || tx_sample !== 24'h000000) begin
      errors++;
      $display("FAIL reset_mid_no_tx: got tx_valids=%0d tx=%h, want 0 000000", txv_cnt - t0, tx_sample);
    end
    run_sample("after_reset", 24'hABCD00, 16'h00FF, 16'hABCD, 24'h00FF00);
    checks++;
    if (overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL after_reset_ovr: got %0d, want 0", overrun_count);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_overrun;
    test_timeout_saturate;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_bridge.md
SAMPLE_BRIDGE -- requirements
Module: sample_bridge

Interface
REQ-001 Parameter IN_WIDTH, default 24, SHALL set the width of the I2S receive and transmit sample words.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the engine sample width (DATA_WIDTH < IN_WIDTH).
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum number of cycles spent waiting on the engine per sample.
REQ-004 clk  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 rx_sample  in  IN_WIDTH  SHALL be the signed received sample, stable whenever rx_toggle is stable.
REQ-007 rx_toggle  in  1  SHALL be the asynchronous receive flag; each transition announces one new rx_sample.
REQ-008 eng_in_sample  out  DATA_WIDTH  SHALL be the signed sample presented to the engine.
REQ-009 eng_sample_ready  out  1  SHALL be a one-cycle strobe that submits eng_in_sample.
REQ-010 eng_ready  in  1  SHALL be the engine ready level: low while busy, high when the result is valid.
REQ-011 eng_out_sample  in  DATA_WIDTH  SHALL be the signed engine result, valid when eng_ready is high.
REQ-012 tx_sample  out  IN_WIDTH  SHALL be the sample for the I2S transmitter.
REQ-013 tx_valid  out  1  SHALL be a one-cycle strobe marking a tx_sample update.
REQ-014 overrun_count  out  8  SHALL count dropped input samples, saturating at 255.
REQ-015 timeout  out  1  SHALL be a sticky engine-timeout flag.

Function
REQ-016 rx_toggle SHALL pass through a two-flop synchroniser plus one history flop; a new-sample event SHALL be the XOR of the last two stages, detected 3 cycles after an input transition.
REQ-017 The FSM SHALL have the states IDLE, WAIT_BUSY, WAIT_DONE and EMIT.
REQ-018 In IDLE, on an event: eng_in_sample SHALL latch the converted rx_sample (REQ-022), eng_sample_ready SHALL be high for the next cycle only, the timeout counter SHALL clear, and the next state SHALL be WAIT_BUSY.
REQ-019 In WAIT_BUSY, eng_ready low SHALL advance the FSM to WAIT_DONE.
REQ-020 In WAIT_DONE, eng_ready high SHALL latch tx_sample = sign-extended eng_out_sample shifted left by IN_WIDTH-DATA_WIDTH and advance the FSM to EMIT.
REQ-021 In EMIT, tx_valid SHALL be high for that one cycle and the FSM SHALL return to IDLE.
REQ-022 Conversion SHALL take the top DATA_WIDTH bits of rx_sample, per REQ-030/031.
REQ-023 An event outside IDLE SHALL drop that sample and increment overrun_count, saturating at 255; an event in EMIT SHALL also count as an overrun.
REQ-024 If the counter reaches TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE, the block SHALL set timeout, leave tx_sample unchanged, issue no tx_valid, and return to IDLE.
REQ-025 eng_ready staying high in WAIT_BUSY SHALL NOT be treated as completion; only a high-to-low-to-high sequence completes a sample.
REQ-026 tx_sample SHALL hold its value between tx_valid strobes.

Reset
REQ-027 When reset is low: FSM = IDLE; eng_in_sample, tx_sample and overrun_count = 0; eng_sample_ready, tx_valid and timeout = 0; synchroniser flops = 0.
REQ-028 Reset asserted mid-operation SHALL abandon the transaction with no tx_valid.
REQ-029 After release, the first detected event SHALL be the first transition of rx_toggle away from 0.

Configuration
REQ-030 With SAMPLE_BRIDGE_ROUND_EN defined, conversion SHALL round half-up by adding bit IN_WIDTH-DATA_WIDTH-1 and saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-031 Without SAMPLE_BRIDGE_ROUND_EN, conversion SHALL truncate (arithmetic drop of the low bits), with no saturation logic.

Structure
REQ-032 The FSM state encoding and the overrun counter width SHALL live in the shared sample_bridge_pkg package.
REQ-033 The synchroniser and edge detector SHALL be one sub-module, toggle_sync.

Verification
REQ-034 rx_sample=24'h123480, toggle; engine model drops eng_ready 2 cycles later, raises it 10 cycles later with 16'h0042 -> eng_in_sample=16'h1235 (round) or 16'h1234 (truncate); tx_sample=24'h004200; one tx_valid.
REQ-035 rx_sample=24'h7FFF80 with SAMPLE_BRIDGE_ROUND_EN -> eng_in_sample=16'h7FFF; rx_sample=24'h800000 -> 16'h8000 in both builds.
REQ-036 Second toggle while in WAIT_DONE -> overrun_count=1, single eng_sample_ready; 300 overruns -> overrun_count=255.
REQ-037 Engine never drops eng_ready -> timeout=1 at 4096 cycles, no tx_valid, next toggle accepted normally.
REQ-038 reset low during WAIT_DONE -> all outputs 0, no tx_valid, FSM in IDLE after release.
